dff_pipeline: RTL and testbench

Parametrised register pipeline built from enable-able flip-flop stages, carrying a WIDTH-bit payload plus a valid bit through DEPTH stages. It generalises the single-bit flop variants (no reset, sync reset, async reset) into one configurable delay line with stall, synchronous flush, an indexed tap and an occupancy count. It is the standard retiming/delay element for datapaths in the design.

---
 rtl/dff_pipeline_pkg.sv | 17 +
 rtl/dff_stage.sv | 57 +++++
 rtl/dff_pipeline.sv | 87 ++++++++
 tb/tb_dff_pipeline.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_pipeline_pkg.sv
// Shared constants and width helpers for the dff_pipeline delay line.
// Select and count widths are derived from DEPTH here so every user agrees on them.
package dff_pipeline_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // A single-stage pipeline still needs a 1-bit tap select.
   function automatic int sel_width(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: a valid flop plus a WIDTH-bit payload register.
// Valid always resets; the payload resets only when DATA_RESET is set.
module dff_stage
   import dff_pipeline_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter bit               DATA_RESET = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_d,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_q
);

   logic             r_vld;
   logic [WIDTH-1:0] r_dat;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vld <= 1'b0;
      end else if (i_clr) begin
         r_vld <= 1'b0;
      end else if (i_en) begin
         r_vld <= i_valid;
      end
   end

   generate
      if (DATA_RESET) begin : g_data_rst
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_dat <= RESET_VAL;
            end else if (i_clr) begin
               r_dat <= RESET_VAL;
            end else if (i_en) begin
               r_dat <= i_d;
            end
         end
      end else begin : g_data_norst
         // Reset-free payload: a flush only drops validity, the data is held.
         always_ff @(posedge i_clk) begin
            if (i_en && !i_clr) begin
               r_dat <= i_d;
            end
         end
      end
   endgenerate

   assign o_valid = r_vld;
   assign o_q     = r_dat;

endmodule

// File: rtl/dff_pipeline.sv
// DEPTH-stage enable-able register pipeline with stall, synchronous flush,
// a combinational stage tap and a registered occupancy count.
module dff_pipeline
   import dff_pipeline_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter int               DEPTH      = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter bit               DATA_RESET = 1'b1,
   localparam int              SELW       = sel_width(DEPTH),
   localparam int              CNTW       = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] q_o,
   input  logic [SELW-1:0]  tap_sel_i,
   output logic             tap_valid_o,
   output logic [WIDTH-1:0] tap_q_o,
   output logic [CNTW-1:0]  occupancy_o
);

   logic [DEPTH-1:0] w_vld;
   logic [WIDTH-1:0] w_dat [DEPTH];
   logic [CNTW-1:0]  r_occ;

   generate
      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         logic             w_v_in;
         logic [WIDTH-1:0] w_d_in;

         if (k == 0) begin : g_head
            assign w_v_in = valid_i;
            assign w_d_in = d_i;
         end else begin : g_body
            assign w_v_in = w_vld[k-1];
            assign w_d_in = w_dat[k-1];
         end

         dff_stage #(
            .WIDTH      (WIDTH),
            .RESET_VAL  (RESET_VAL),
            .DATA_RESET (DATA_RESET)
         ) u_stage (
            .i_clk   (clk),
            .i_rst   (reset),
            .i_en    (en_i),
            .i_clr   (flush_i),
            .i_valid (w_v_in),
            .i_d     (w_d_in),
            .o_valid (w_vld[k]),
            .o_q     (w_dat[k])
         );
      end
   endgenerate

   // Tracks popcount(w_vld) incrementally: +1 for an entry in, -1 for one leaving.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_occ <= '0;
      end else if (flush_i) begin
         r_occ <= '0;
      end else if (en_i) begin
         r_occ <= r_occ + CNTW'(valid_i) - CNTW'(w_vld[DEPTH-1]);
      end
   end

   always_comb begin
      tap_valid_o = 1'b0;
      tap_q_o     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (tap_sel_i == SELW'(k)) begin
            tap_valid_o = w_vld[k];
            tap_q_o     = w_dat[k];
         end
      end
   end

   assign valid_o     = w_vld[DEPTH-1];
   assign q_o         = w_dat[DEPTH-1];
   assign occupancy_o = r_occ;

endmodule

// File: tb/tb_dff_pipeline.sv
// Bench for dff_pipeline: DEPTH=4 with and without data reset, plus DEPTH=1,
// compared against a history-queue model of the accepted input stream.
module tb_dff_pipeline;

   localparam int         W  = 8;
   localparam int         D  = 4;
   localparam logic [7:0] RV = 8'hA5;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
   } ent_t;

   logic       clk;
   logic       reset;
   logic       en_i;
   logic       flush_i;
   logic       valid_i;
   logic [7:0] d_i;
   logic [1:0] tap_sel;
   logic       tap_sel1;

   logic       a_valid, a_tv, b_valid, b_tv, c_valid, c_tv;
   logic [7:0] a_q, a_tq, b_q, b_tq, c_q, c_tq;
   logic [2:0] a_occ, b_occ;
   logic [0:0] c_occ;

   int errors = 0;
   int checks = 0;

   // h4[k] is the expected content of stage k; h1 models the DEPTH=1 instance.
   ent_t h4[$];
   ent_t h1;

   dff_pipeline #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV), .DATA_RESET(1'b1)) u_a (
      .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i), .d_i(d_i),
      .valid_o(a_valid), .q_o(a_q), .tap_sel_i(tap_sel), .tap_valid_o(a_tv), .tap_q_o(a_tq),
      .occupancy_o(a_occ));

   dff_pipeline #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV), .DATA_RESET(1'b0)) u_b (
      .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i), .d_i(d_i),
      .valid_o(b_valid), .q_o(b_q), .tap_sel_i(tap_sel), .tap_valid_o(b_tv), .tap_q_o(b_tq),
      .occupancy_o(b_occ));

   dff_pipeline #(.WIDTH(W), .DEPTH(1), .RESET_VAL(RV), .DATA_RESET(1'b1)) u_c (
      .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i), .d_i(d_i),
      .valid_o(c_valid), .q_o(c_q), .tap_sel_i(tap_sel1), .tap_valid_o(c_tv), .tap_q_o(c_tq),
      .occupancy_o(c_occ));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_clear();
      h4.delete();
      for (int k = 0; k < D; k++) h4.push_back('{1'b0, RV});
      h1 = '{1'b0, RV};
   endtask

   task automatic m_advance();
      h4.push_front('{valid_i, d_i});
      void'(h4.pop_back());
      h1 = '{valid_i, d_i};
   endtask

   function automatic int occ4();
      int n = 0;
      foreach (h4[k]) if (h4[k].v) n++;
      return n;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".a_valid"}, 32'(a_valid), 32'(h4[D-1].v));
      chk({tag, ".a_q"},     32'(a_q),     32'(h4[D-1].d));
      chk({tag, ".a_occ"},   32'(a_occ),   32'(occ4()));
      chk({tag, ".a_tv"},    32'(a_tv),    32'(h4[tap_sel].v));
      chk({tag, ".a_tq"},    32'(a_tq),    32'(h4[tap_sel].d));
      chk({tag, ".b_valid"}, 32'(b_valid), 32'(h4[D-1].v));
      chk({tag, ".b_occ"},   32'(b_occ),   32'(occ4()));
      chk({tag, ".b_tv"},    32'(b_tv),    32'(h4[tap_sel].v));
      if (h4[D-1].v) chk({tag, ".b_q"}, 32'(b_q), 32'(h4[D-1].d));
      if (h4[tap_sel].v) chk({tag, ".b_tq"}, 32'(b_tq), 32'(h4[tap_sel].d));
      chk({tag, ".c_valid"}, 32'(c_valid), 32'(h1.v));
      chk({tag, ".c_q"},     32'(c_q),     32'(h1.d));
      chk({tag, ".c_occ"},   32'(c_occ),   32'(h1.v));
      if (tap_sel1 == 1'b0) begin
         chk({tag, ".c_tv"}, 32'(c_tv), 32'(h1.v));
         chk({tag, ".c_tq"}, 32'(c_tq), 32'(h1.d));
      end else begin
         chk({tag, ".c_tv_oor"}, 32'(c_tv), 32'd0);
         chk({tag, ".c_tq_oor"}, 32'(c_tq), 32'd0);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (flush_i) m_clear();
      else if (en_i) m_advance();
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b1; en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; d_i = '0;
      tap_sel = '0; tap_sel1 = 1'b0;
      m_clear();

      // Reset then idle
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset.q_rv", 32'(a_q), 32'hA5);
      reset = 1'b0;
      step("idle");

      // Streaming 01..06, then drain
      en_i = 1'b1; valid_i = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         d_i = 8'(i);
         step("stream");
         if (i == 4) chk("stream.first_out", {23'd0, a_valid, a_q}, {23'd0, 1'b1, 8'h01});
         if (i >= 4) chk("stream.occ_full", 32'(a_occ), 32'd4);
      end
      valid_i = 1'b0;
      repeat (4) step("drain");

      // Stall with 3 entries inside
      flush_i = 1'b1; step("pre_stall_flush"); flush_i = 1'b0;
      valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin d_i = 8'h21 + 8'(i); step("stall_fill"); end
      en_i = 1'b0; d_i = 8'hEE;
      repeat (5) step("stall_hold");
      chk("stall.occ", 32'(a_occ), 32'd3);
      chk("stall.valid_o", 32'(a_valid), 32'd0);
      en_i = 1'b1; valid_i = 1'b0;
      step("stall_resume");
      chk("stall.latency", {23'd0, a_valid, a_q}, {23'd0, 1'b1, 8'h21});
      repeat (3) step("stall_drain");

      // Bubbles and tap
      flush_i = 1'b1; step("pre_bubble_flush"); flush_i = 1'b0;
      valid_i = 1'b1; d_i = 8'h11; step("bubble");
      valid_i = 1'b0; d_i = 8'h22; step("bubble");
      valid_i = 1'b1; d_i = 8'h33; step("bubble");
      en_i = 1'b0;
      tap_sel = 2'd1; #1;
      chk("tap1.valid", 32'(a_tv), 32'd0);
      tap_sel = 2'd2; #1;
      chk("tap2.valid", 32'(a_tv), 32'd1);
      chk("tap2.q", 32'(a_tq), 32'h11);
      chk("tap.occ", 32'(a_occ), 32'd2);
      tap_sel1 = 1'b1; #1;
      chk("tap_oor.valid", 32'(c_tv), 32'd0);
      chk("tap_oor.q", 32'(c_tq), 32'd0);
      tap_sel = 2'd0; tap_sel1 = 1'b0;

      // Flush wins over enable
      en_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1; d_i = 8'h77;
      step("flush_en");
      flush_i = 1'b0; en_i = 1'b0;
      chk("flush.occ", 32'(a_occ), 32'd0);
      chk("flush.q", 32'(a_q), 32'hA5);
      for (int k = 0; k < D; k++) begin
         tap_sel = 2'(k); #1;
         chk("flush.tap_valid", 32'(a_tv), 32'd0);
         chk("flush.tap_q", 32'(a_tq), 32'hA5);
      end
      tap_sel = 2'd0;

      // Async reset mid-stream
      en_i = 1'b1; valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin d_i = 8'h41 + 8'(i); step("prefill"); end
      chk("prefill.occ", 32'(a_occ), 32'd4);
      #1 reset = 1'b1;
      #1;
      m_clear();
      chk("areset.valid_o", 32'(a_valid), 32'd0);
      chk("areset.occ", 32'(a_occ), 32'd0);
      chk("areset.q", 32'(a_q), 32'hA5);
      chk("areset.b_valid", 32'(b_valid), 32'd0);
      chk("areset.b_occ", 32'(b_occ), 32'd0);
      #1 reset = 1'b0;
      d_i = 8'h55; step("post_reset");
      valid_i = 1'b0;
      repeat (3) step("post_reset");
      chk("post_reset.latency", {23'd0, a_valid, a_q}, {23'd0, 1'b1, 8'h55});

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         en_i     = ($urandom_range(0, 3) != 0);
         flush_i  = ($urandom_range(0, 19) == 0);
         valid_i  = 1'($urandom_range(0, 1));
         d_i      = 8'($urandom_range(0, 255));
         tap_sel  = 2'($urandom_range(0, 3));
         tap_sel1 = 1'($urandom_range(0, 1));
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
